// File: rtl/regfile_dump.sv
// regfile_dump: debug read-out engine on the regfile read side.
// On a start pulse it halts the core, walks the port-A read address across
// R0..LAST, and streams each word over a valid/ready link.
// Ports:
//   clock, reset_n        single clock, synchronous active-low reset
//   start                 1-cycle dump request, honoured only when idle
//   halt_req / halt_ack   core stall request / core stalled acknowledge
//   ra / radata           regfile port-A address out, read data in
//   out_valid/out_ready   beat handshake; out_data/out_index carry the word
//   busy                  engine not idle
//   done / aborted        1-cycle completion / early-termination pulses
module regfile_dump #(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned DW       = 32,
  parameter int unsigned SKIP_R31 = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  output logic          halt_req,
  input  logic          halt_ack,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] radata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  typedef enum logic [2:0] {IDLE, HALT, READ, SEND, DONE} state_t;

  // R31 is hardwired to zero when SKIP_R31 is set, so the walk stops one short.
  localparam int unsigned   LAST_I = (SKIP_R31 != 0) ? NREGS - 2 : NREGS - 1;
  localparam logic [AW-1:0] LAST   = AW'(LAST_I);

  state_t        state;
  logic [AW-1:0] idx;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      halt_req  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HALT;
            idx      <= '0;
            halt_req <= 1'b1;
          end
        end
        HALT: begin
          if (halt_ack) state <= READ;
        end
        READ: begin
          if (!halt_ack) begin
            state    <= IDLE;
            halt_req <= 1'b0;
            aborted  <= 1'b1;
          end else begin
            out_data  <= radata;
            out_index <= idx;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Losing the halt outranks a same-cycle handshake: the beat is dropped.
          if (!halt_ack) begin
            state     <= IDLE;
            halt_req  <= 1'b0;
            out_valid <= 1'b0;
            aborted   <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST) begin
              state    <= DONE;
              halt_req <= 1'b0;
              done     <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          halt_req <= 1'b0;
        end
      endcase
    end
  end

  // The address is presented only while the core is known to be halted.
  always_comb begin
    ra = '0;
    if (state == READ) ra = idx;
  end

  always_comb busy = (state != IDLE);

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        halt_ack = 1'b1;
  logic        out_ready = 1'b1;
  logic        sel = 1'b0;   // 0: SKIP_R31=1 instance, 1: SKIP_R31=0 instance

  logic        start0, start1;
  logic        hr0, hr1, ov0, ov1, busy0, busy1, done0, done1, ab0, ab1;
  logic [4:0]  ra0, ra1, oi0, oi1;
  logic [31:0] rd0, rd1, od0, od1;

  logic        hr, ov, busyx, donex, abx;
  logic [4:0]  rax, oi;
  logic [31:0] od;

  always #5 clock = ~clock;

  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd31) ? 32'h0 : 32'h100 + {27'b0, a};
  endfunction

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign rd0 = rf(ra0);
  assign rd1 = rf(ra1);

  regfile_dump #(.NREGS(32), .AW(5), .DW(32), .SKIP_R31(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .halt_req(hr0),
    .halt_ack(halt_ack), .ra(ra0), .radata(rd0), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0), .out_index(oi0), .busy(busy0),
    .done(done0), .aborted(ab0));

  regfile_dump #(.NREGS(32), .AW(5), .DW(32), .SKIP_R31(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .halt_req(hr1),
    .halt_ack(halt_ack), .ra(ra1), .radata(rd1), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .out_index(oi1), .busy(busy1),
    .done(done1), .aborted(ab1));

  always_comb begin
    hr    = sel ? hr1   : hr0;
    ov    = sel ? ov1   : ov0;
    busyx = sel ? busy1 : busy0;
    donex = sel ? done1 : done0;
    abx   = sel ? ab1   : ab0;
    rax   = sel ? ra1   : ra0;
    oi    = sel ? oi1   : oi0;
    od    = sel ? od1   : od0;
  end

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t q[$];
  int    beats = 0, dones = 0, aborts = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_od = '0;
  logic [4:0]  prev_oi = '0;

  // Inputs change 1 time unit after posedge, so the negedge values are the
  // ones the next posedge samples.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (prev_stall && halt_ack) begin
        chk("stall_valid", {31'b0, ov}, 32'd1);
        chk("stall_data", od, prev_od);
        chk("stall_index", {27'b0, oi}, {27'b0, prev_oi});
      end
      if (ov === 1'b1 && out_ready && halt_ack) begin
        if (q.size() == 0) begin
          chk("extra_beat", {27'b0, oi}, 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("beat_index", {27'b0, oi}, {27'b0, e.idx});
          chk("beat_data", od, e.data);
        end
        beats++;
      end
      prev_stall = (ov === 1'b1) && !out_ready && halt_ack;
      prev_od = od;
      prev_oi = oi;
      if (donex === 1'b1) dones++;
      if (abx === 1'b1) aborts++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  typedef struct {
    int sel, mode, ack_delay, abort_at, poke;
    int exp_beats, exp_done, exp_abort, exp_left, exp_cyc;
  } vec_t;

  vec_t tbl[6];

  task automatic load_expect(input logic s);
    int last;
    beat_t b;
    q.delete();
    last = s ? 31 : 30;
    for (int i = 0; i <= last; i++) begin
      b.idx = 5'(i);
      b.data = rf(5'(i));
      q.push_back(b);
    end
  endtask

  // Caller is positioned just after a posedge.
  task automatic run_row(input vec_t v, output int cyc);
    logic poked;
    poked = 1'b0;
    sel = v.sel[0];
    beats = 0; dones = 0; aborts = 0;
    load_expect(v.sel[0]);
    halt_ack = (v.ack_delay == 0);
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0;
    for (int k = 0; k < v.ack_delay; k++) begin
      @(posedge clock); #1;
      cyc++;
      chk("halt_hold", {31'b0, hr}, 32'd1);
      chk("no_valid_unacked", {31'b0, ov}, 32'd0);
    end
    halt_ack = 1'b1;
    do begin
      @(posedge clock); #1;
      cyc++;
      start = 1'b0;
      if (busyx) begin
        out_ready = (v.mode == 1) ? ((cyc % 3) == 0) : 1'b1;
        if (v.abort_at >= 0 && beats == v.abort_at && ov) halt_ack = 1'b0;
        if (v.poke != 0 && !poked && beats == 3 && !ov) begin
          start = 1'b1;
          poked = 1'b1;
        end
      end
    end while (busyx && cyc < 400);
    chk("dump_timeout", {31'b0, busyx}, 32'd0);
    @(posedge clock); #1;
    halt_ack = 1'b1;
    out_ready = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    int cyc, n;

    //        sel mode dly abort poke beats done ab left cyc
    tbl[0] = '{0, 0, 0,  -1,  0,  31,   1,   0, 0,   64};
    tbl[1] = '{1, 0, 0,  -1,  0,  32,   1,   0, 0,   66};
    tbl[2] = '{0, 1, 0,  -1,  0,  31,   1,   0, 0,   -1};
    tbl[3] = '{0, 0, 10, -1,  0,  31,   1,   0, 0,   74};
    tbl[4] = '{0, 0, 0,   5,  0,   5,   0,   1, 26,  13};
    tbl[5] = '{0, 0, 0,  -1,  1,  31,   1,   0, 0,   64};

    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_halt_req", {31'b0, hr}, 32'd0);
    chk("rst_valid", {31'b0, ov}, 32'd0);
    chk("rst_data", od, 32'd0);
    chk("rst_index", {27'b0, oi}, 32'd0);
    chk("rst_busy", {31'b0, busyx}, 32'd0);
    chk("rst_done", {31'b0, donex}, 32'd0);
    chk("rst_aborted", {31'b0, abx}, 32'd0);
    chk("rst_ra", {27'b0, rax}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    foreach (tbl[r]) begin
      run_row(tbl[r], cyc);
      chk($sformatf("row%0d_beats", r), beats, tbl[r].exp_beats);
      chk($sformatf("row%0d_done", r), dones, tbl[r].exp_done);
      chk($sformatf("row%0d_aborted", r), aborts, tbl[r].exp_abort);
      chk($sformatf("row%0d_left", r), q.size(), tbl[r].exp_left);
      if (tbl[r].exp_cyc >= 0) chk($sformatf("row%0d_cycles", r), cyc, tbl[r].exp_cyc);
      chk($sformatf("row%0d_halt_req_end", r), {31'b0, hr}, 32'd0);
      chk($sformatf("row%0d_busy_end", r), {31'b0, busyx}, 32'd0);
    end

    // Reset while presenting index 7.
    sel = 1'b0;
    beats = 0; dones = 0; aborts = 0;
    load_expect(1'b0);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (!(beats == 7 && ov === 1'b1) && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    chk("reset_reach_idx7", {27'b0, oi}, 32'd7);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("midrst_halt_req", {31'b0, hr}, 32'd0);
    chk("midrst_valid", {31'b0, ov}, 32'd0);
    chk("midrst_data", od, 32'd0);
    chk("midrst_index", {27'b0, oi}, 32'd0);
    chk("midrst_busy", {31'b0, busyx}, 32'd0);
    chk("midrst_done", {31'b0, donex}, 32'd0);
    chk("midrst_aborted", {31'b0, abx}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("midrst_beats", beats, 32'd7);
    chk("midrst_no_abort_pulse", aborts, 32'd0);

    run_row(tbl[0], cyc);
    chk("post_rst_beats", beats, 32'd31);
    chk("post_rst_done", dones, 32'd1);
    chk("post_rst_left", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
